// File: rtl/data_mem_sized.sv
// Byte/half/word data RAM with a valid/ready request port, an RD_LATENCY-deep response
// pipeline and a post-reset clear FSM. Optional bounds checking: DMEM_BOUNDS_CHECK_EN.
module data_mem_sized #(
   parameter int DEPTH_WORDS = 16384,
   parameter int RD_LATENCY  = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        init_busy
);

   localparam int            AW       = $clog2(DEPTH_WORDS);
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

   typedef enum logic [0:0] {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] clr_cnt_q, clr_cnt_d;
   logic          clr_active;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_INIT;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      case (state_q)
         ST_INIT: begin
            clr_cnt_d = clr_cnt_q + AW'(1);
            if (clr_cnt_q == LAST_IDX) state_d = ST_READY;
         end
         default: state_d = ST_READY;
      endcase
   end

   always_comb begin
      init_busy  = 1'b0;
      req_ready  = 1'b0;
      clr_active = 1'b0;
      case (state_q)
         ST_INIT: begin
            init_busy  = 1'b1;
            clr_active = 1'b1;
         end
         default: req_ready = 1'b1;
      endcase
   end

   // Request decode
   logic          accept;
   logic          misalign;
   logic          out_of_range;
   logic          req_err;
   logic [AW-1:0] req_idx;
   logic [1:0]    req_lane;

   // A request presented while rst_n is low must not touch memory.
   assign accept   = req_valid & req_ready & rst_n;
   assign req_idx  = req_addr[AW+1:2];
   assign req_lane = req_addr[1:0];

   always_comb begin
      case (req_size)
         2'b00:   misalign = 1'b0;
         2'b01:   misalign = req_addr[0];
         2'b10:   misalign = |req_addr[1:0];
         default: misalign = 1'b1;
      endcase
   end

`ifdef DMEM_BOUNDS_CHECK_EN
   assign out_of_range = |req_addr[31:AW+2];
`else
   logic unused_addr_hi;
   assign unused_addr_hi = ^req_addr[31:AW+2];
   assign out_of_range   = 1'b0;
`endif

   assign req_err = misalign | out_of_range;

   // Store lane steering
   logic [3:0]    wr_be;
   logic [31:0]   wr_lanes;
   logic          store_ok;
   logic          rd_en;
   logic [AW-1:0] mem_idx;
   logic [31:0]   mem_wdata;
   logic [3:0]    mem_we;

   always_comb begin
      wr_be    = 4'b0000;
      wr_lanes = req_wdata;
      case (req_size)
         2'b00: begin
            wr_be    = 4'b0001 << req_lane;
            wr_lanes = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            wr_be    = 4'b0011 << req_lane;
            wr_lanes = {2{req_wdata[15:0]}};
         end
         2'b10:   wr_be = 4'b1111;
         default: wr_be = 4'b0000;
      endcase
   end

   assign store_ok  = accept & req_we & ~req_err;
   assign rd_en     = accept & ~req_we & ~req_err;
   assign mem_idx   = clr_active ? clr_cnt_q : req_idx;
   assign mem_wdata = clr_active ? 32'h0 : wr_lanes;
   assign mem_we    = clr_active ? 4'hF : (store_ok ? wr_be : 4'h0);

   genvar gi;
   for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] ram [DEPTH_WORDS];
      logic [7:0] rd_q;

      always_ff @(posedge clk) begin
         if (mem_we[gi]) ram[mem_idx] <= mem_wdata[8*gi +: 8];
         if (rd_en)      rd_q         <= ram[mem_idx];
      end
   end

   // First pipeline stage: request attributes captured alongside the RAM read
   logic       s0_valid_q;
   logic       s0_err_q;
   logic       s0_load_q;
   logic       s0_uns_q;
   logic [1:0] s0_size_q;
   logic [1:0] s0_lane_q;

   always_ff @(posedge clk) begin
      if (!rst_n) s0_valid_q <= 1'b0;
      else        s0_valid_q <= accept;
      if (accept) begin
         s0_err_q  <= req_err;
         s0_load_q <= ~req_we;
         s0_uns_q  <= req_unsigned;
         s0_size_q <= req_size;
         s0_lane_q <= req_lane;
      end
   end

   logic [31:0] rd_word;
   logic [31:0] shifted;
   logic [31:0] ext_data;

   assign rd_word = {g_lane[3].rd_q, g_lane[2].rd_q, g_lane[1].rd_q, g_lane[0].rd_q};
   assign shifted = rd_word >> {s0_lane_q, 3'b000};

   always_comb begin
      ext_data = 32'h0;
      if (s0_load_q && !s0_err_q) begin
         case (s0_size_q)
            2'b00:   ext_data = {{24{~s0_uns_q & shifted[7]}}, shifted[7:0]};
            2'b01:   ext_data = {{16{~s0_uns_q & shifted[15]}}, shifted[15:0]};
            default: ext_data = rd_word;
         endcase
      end
   end

   // Extra delay stages; the extended result travels down the chain unchanged.
   for (gi = 0; gi < RD_LATENCY; gi++) begin : g_stage
      logic        v;
      logic        e;
      logic [31:0] d;

      if (gi == 0) begin : g_head
         assign v = s0_valid_q;
         assign e = s0_err_q;
         assign d = ext_data;
      end else begin : g_dly
         always_ff @(posedge clk) begin
            if (!rst_n) v <= 1'b0;
            else        v <= g_stage[gi-1].v;
            e <= g_stage[gi-1].e;
            d <= g_stage[gi-1].d;
         end
      end
   end

   logic        out_v;
   logic        out_e;
   logic [31:0] out_d;
   logic [31:0] hold_rdata_q;
   logic        hold_err_q;

   assign out_v = g_stage[RD_LATENCY-1].v;
   assign out_e = g_stage[RD_LATENCY-1].e;
   assign out_d = g_stage[RD_LATENCY-1].d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hold_rdata_q <= 32'h0;
         hold_err_q   <= 1'b0;
      end else if (out_v) begin
         hold_rdata_q <= out_d;
         hold_err_q   <= out_e;
      end
   end

   assign resp_valid = out_v;
   assign resp_rdata = out_v ? out_d : hold_rdata_q;
   assign resp_err   = out_v ? out_e : hold_err_q;

endmodule

// File: tb/tb_data_mem_sized.sv
// Bench for data_mem_sized: two instances (latency 1 and 2) share stimulus; responses are
// scored against a byte-array reference model and a table of directed vectors.
module tb_data_mem_sized;

   localparam int DW   = 16;
   localparam int LAT0 = 1;
   localparam int LAT1 = 2;

   bit          clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;

   logic        rdy0, rv0, err0, busy0;
   logic [31:0] rd0;
   logic        rdy1, rv1, err1, busy1;
   logic [31:0] rd1;

   always #5 clk = ~clk;

   data_mem_sized #(.DEPTH_WORDS(DW), .RD_LATENCY(LAT0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy0),
      .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv0),
      .resp_rdata(rd0), .resp_err(err0), .init_busy(busy0));

   data_mem_sized #(.DEPTH_WORDS(DW), .RD_LATENCY(LAT1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy1),
      .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv1),
      .resp_rdata(rd1), .resp_err(err1), .init_busy(busy1));

   typedef struct {
      int          due;
      logic        err;
      logic [31:0] data;
      string       nm;
   } exp_t;

   typedef struct {
      logic        we;
      logic [1:0]  sz;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        err;
      logic [31:0] rd;
      string       nm;
   } vec_t;

   exp_t        q0[$];
   exp_t        q1[$];
   logic [7:0]  mdl [64];
   logic [31:0] last_d [2];
   logic        last_e [2];
   int          cyc     = 0;
   int          checks  = 0;
   int          errors  = 0;
   bit          chk_en  = 1'b0;
   bit          rst_seen = 1'b0;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_seen <= !rst_n;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Byte-addressed little-endian memory; alignment and range rules applied directly.
   task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic err, output logic [31:0] rd);
      int unsigned nb, base;
      logic [31:0] val;
      nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      err = (sz == 2'd3) || ((a % nb) != 0);
`ifdef DMEM_BOUNDS_CHECK_EN
      if (a >= 64) err = 1'b1;
`endif
      base = a % 64;
      rd   = 32'h0;
      if (!err) begin
         if (we) begin
            for (int i = 0; i < int'(nb); i++) mdl[6'(base + i)] = wd[8*i +: 8];
         end else begin
            val = 32'h0;
            for (int i = 0; i < int'(nb); i++) val = val | (32'(mdl[6'(base + i)]) << (8*i));
            if (!uns && nb < 4 && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8*nb));
            rd = val;
         end
      end
   endtask

   task automatic port_chk(input int id, input logic v, input logic e, input logic [31:0] d);
      exp_t h;
      bit   hit;
      hit = 1'b0;
      if (id == 0) begin
         if (q0.size() != 0 && q0[0].due == cyc) begin h = q0.pop_front(); hit = 1'b1; end
      end else begin
         if (q1.size() != 0 && q1[0].due == cyc) begin h = q1.pop_front(); hit = 1'b1; end
      end
      if (hit) begin
         chk($sformatf("%s dut%0d resp_valid", h.nm, id), 32'(v), 32'd1);
         chk($sformatf("%s dut%0d resp_err", h.nm, id), 32'(e), 32'(h.err));
         chk($sformatf("%s dut%0d resp_rdata", h.nm, id), d, h.data);
         last_d[id] = h.data;
         last_e[id] = h.err;
      end else begin
         chk($sformatf("idle dut%0d resp_valid", id), 32'(v), 32'd0);
         chk($sformatf("hold dut%0d resp_rdata", id), d, last_d[id]);
         chk($sformatf("hold dut%0d resp_err", id), 32'(e), 32'(last_e[id]));
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         if (rst_seen) begin
            q0.delete();
            q1.delete();
            last_d[0] = 32'h0; last_d[1] = 32'h0;
            last_e[0] = 1'b0;  last_e[1] = 1'b0;
         end
         port_chk(0, rv0, err0, rd0);
         port_chk(1, rv1, err1, rd1);
      end
   end

   // Called at a negedge; presents one request for exactly one cycle.
   task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input bit given, input logic ge, input logic [31:0] gd,
                        input string nm);
      logic me;
      logic [31:0] md;
      exp_t x;
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
      req_addr = a; req_wdata = wd;
      chk({nm, " dut0 req_ready"}, 32'(rdy0), 32'd1);
      chk({nm, " dut1 req_ready"}, 32'(rdy1), 32'd1);
      model(we, sz, uns, a, wd, me, md);
      x.err  = given ? ge : me;
      x.data = given ? gd : md;
      x.nm   = nm;
      x.due  = cyc + LAT0; q0.push_back(x);
      x.due  = cyc + LAT1; q1.push_back(x);
      $display("req %-8s we=%0d sz=%0d uns=%0d addr=%h wd=%h -> err=%0d rd=%h",
               nm, we, sz, uns, a, wd, x.err, x.data);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic init_check(input string nm);
      for (int k = 0; k < DW; k++) begin
         chk($sformatf("%s busy0 c%0d", nm, k), 32'(busy0), 32'd1);
         chk($sformatf("%s ready0 c%0d", nm, k), 32'(rdy0), 32'd0);
         chk($sformatf("%s busy1 c%0d", nm, k), 32'(busy1), 32'd1);
         chk($sformatf("%s ready1 c%0d", nm, k), 32'(rdy1), 32'd0);
         @(negedge clk);
      end
      chk({nm, " busy0 done"}, 32'(busy0), 32'd0);
      chk({nm, " ready0 done"}, 32'(rdy0), 32'd1);
      chk({nm, " busy1 done"}, 32'(busy1), 32'd0);
      chk({nm, " ready1 done"}, 32'(rdy1), 32'd1);
      $display("init %s: clear sequence observed", nm);
   endtask

   function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic uns,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic e, input logic [31:0] r, input string nm);
      vec_t v;
      v.we = we; v.sz = sz; v.uns = uns; v.addr = a; v.wd = wd;
      v.err = e; v.rd = r; v.nm = nm;
      return v;
   endfunction

   vec_t        vecs[$];
   logic [1:0]  r_sz;
   logic [31:0] r_a;
   logic        r_we;

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
      req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
      last_d[0] = 32'h0; last_d[1] = 32'h0; last_e[0] = 1'b0; last_e[1] = 1'b0;
      for (int i = 0; i < 64; i++) mdl[i] = 8'h00;

      vecs.push_back(mk(0, 2'd2, 0, 32'h3C, 32'h0,        0, 32'h0000_0000, "lw3c"));
      vecs.push_back(mk(1, 2'd2, 0, 32'h08, 32'hDEADBEEF, 0, 32'h0000_0000, "sw8"));
      vecs.push_back(mk(0, 2'd0, 0, 32'h09, 32'h0,        0, 32'hFFFF_FFBE, "lb9"));
      vecs.push_back(mk(0, 2'd0, 1, 32'h09, 32'h0,        0, 32'h0000_00BE, "lbu9"));
      vecs.push_back(mk(0, 2'd1, 0, 32'h0A, 32'h0,        0, 32'hFFFF_DEAD, "lha"));
      vecs.push_back(mk(0, 2'd1, 1, 32'h0A, 32'h0,        0, 32'h0000_DEAD, "lhua"));
      vecs.push_back(mk(1, 2'd2, 0, 32'h04, 32'h11223344, 0, 32'h0000_0000, "sw4"));
      vecs.push_back(mk(1, 2'd0, 0, 32'h05, 32'hFFFF_FF77, 0, 32'h0000_0000, "sb5"));
      vecs.push_back(mk(0, 2'd2, 0, 32'h04, 32'h0,        0, 32'h11227744, "lw4a"));
      vecs.push_back(mk(1, 2'd1, 0, 32'h06, 32'h1234_ABCD, 0, 32'h0000_0000, "sh6"));
      vecs.push_back(mk(0, 2'd2, 0, 32'h04, 32'h0,        0, 32'hABCD7744, "lw4b"));
      vecs.push_back(mk(0, 2'd2, 0, 32'h06, 32'h0,        1, 32'h0000_0000, "lw6err"));
      vecs.push_back(mk(1, 2'd1, 0, 32'h03, 32'hFFFF_FFFF, 1, 32'h0000_0000, "sh3err"));
      vecs.push_back(mk(1, 2'd3, 0, 32'h04, 32'hFFFF_FFFF, 1, 32'h0000_0000, "sz3err"));
      vecs.push_back(mk(0, 2'd2, 0, 32'h04, 32'h0,        0, 32'hABCD7744, "lw4c"));
      vecs.push_back(mk(0, 2'd2, 0, 32'h00, 32'h0,        0, 32'h0000_0000, "lw0pre"));
      vecs.push_back(mk(1, 2'd2, 0, 32'h00, 32'hCAFEF00D, 0, 32'h0000_0000, "sw0"));
      vecs.push_back(mk(0, 2'd2, 0, 32'h00, 32'h0,        0, 32'hCAFEF00D, "lw0"));
`ifdef DMEM_BOUNDS_CHECK_EN
      vecs.push_back(mk(0, 2'd2, 0, 32'h40, 32'h0,        1, 32'h0000_0000, "lw40"));
      vecs.push_back(mk(1, 2'd2, 0, 32'h44, 32'h55555555, 1, 32'h0000_0000, "sw44"));
      vecs.push_back(mk(0, 2'd2, 0, 32'h04, 32'h0,        0, 32'hABCD7744, "lw4d"));
`else
      vecs.push_back(mk(0, 2'd2, 0, 32'h40, 32'h0,        0, 32'hCAFEF00D, "lw40"));
      vecs.push_back(mk(1, 2'd2, 0, 32'h44, 32'h55555555, 0, 32'h0000_0000, "sw44"));
      vecs.push_back(mk(0, 2'd2, 0, 32'h04, 32'h0,        0, 32'h55555555, "lw4d"));
`endif
      vecs.push_back(mk(0, 2'd2, 0, 32'h08, 32'h0,        0, 32'hDEADBEEF, "lw8"));

      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      rst_n  = 1'b1;
      init_check("boot");

      foreach (vecs[i])
         issue(vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd,
               1'b1, vecs[i].err, vecs[i].rd, vecs[i].nm);
      repeat (3) @(negedge clk);

      for (int i = 0; i < 300; i++) begin
         r_sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         r_a  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 255))
                                            : 32'($urandom_range(0, 63));
         if ($urandom_range(0, 3) != 0) begin
            if (r_sz == 2'b01) r_a[0] = 1'b0;
            if (r_sz == 2'b10) r_a[1:0] = 2'b00;
         end
         r_we = 1'($urandom_range(0, 1));
         issue(r_we, r_sz, 1'($urandom_range(0, 1)), r_a, $urandom, 1'b0, 1'b0, 32'h0, "rand");
         if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
      repeat (3) @(negedge clk);

      // Reset while loads are still in the pipeline
      issue(1, 2'd2, 0, 32'h10, 32'h5A5A1234, 1'b1, 1'b0, 32'h0, "sw10");
      issue(0, 2'd2, 0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h5A5A1234, "lda");
      issue(0, 2'd2, 0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h5A5A1234, "ldb");
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 64; i++) mdl[i] = 8'h00;
      init_check("rerun");
      issue(0, 2'd2, 0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h0, "lw10clr");
      issue(0, 2'd2, 0, 32'h08, 32'h0, 1'b1, 1'b0, 32'h0, "lw8clr");

      repeat (6) @(negedge clk);
      chk("drain dut0 pending", 32'(q0.size()), 32'd0);
      chk("drain dut1 pending", 32'(q1.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
